// File: rtl/bsg_fpu_pkg.sv
// bsg_fpu_pkg: shared FPU types; holds the normalizer FSM state encoding
package bsg_fpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bsg_fpu_normalize_state_e;

endpackage

// File: rtl/bsg_fpu_lzc_step.sv
// bsg_fpu_lzc_step: combinational leading-zero count over one step_p-bit window
module bsg_fpu_lzc_step
    import bsg_fpu_pkg::*;
#(
    parameter int step_p     = 8,
    parameter int lg_step_lp = (step_p > 1) ? $clog2(step_p) : 1
) (
    input  logic [step_p-1:0]     data_i,
    output logic [lg_step_lp-1:0] count_o,
    output logic                  zero_o
);

    // scan upward so the most significant set bit is the last one to write the count
    always_comb begin
        count_o = '0;
        for (int i = 0; i < step_p; i++)
            if (data_i[i]) count_o = lg_step_lp'(step_p - 1 - i);
    end

    assign zero_o = ~|data_i;

endmodule

// File: rtl/bsg_fpu_normalize_iter.sv
// bsg_fpu_normalize_iter: iterative left-normalizer, up to step_p bits per cycle; BSG_FPU_NORMALIZE_ZERO_FAST_EN sends zero inputs straight to DONE
module bsg_fpu_normalize_iter
    import bsg_fpu_pkg::*;
#(
    parameter int width_p    = 32,
    parameter int step_p     = 8,
    parameter int lg_width_p = $clog2(width_p + 1)
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  v_i,
    input  logic [width_p-1:0]    data_i,
    input  logic                  sticky_i,
    output logic                  ready_o,
    output logic                  v_o,
    output logic [width_p-1:0]    data_o,
    output logic [lg_width_p-1:0] shamt_o,
    output logic                  zero_o,
    output logic                  sticky_o,
    input  logic                  yumi_i
);

    localparam int lg_step_lp = (step_p > 1) ? $clog2(step_p) : 1;

    bsg_fpu_normalize_state_e state_r;
    logic [width_p-1:0]    data_r;
    logic [lg_width_p-1:0] shamt_r;
    logic                  zero_r;
    logic                  sticky_r;
    logic [lg_step_lp-1:0] lzc;
    logic                  win_zero;

    bsg_fpu_lzc_step #(.step_p(step_p), .lg_step_lp(lg_step_lp)) lzc_step (
        .data_i  (data_r[width_p-1 -: step_p]),
        .count_o (lzc),
        .zero_o  (win_zero)
    );

    // FSM plus datapath: accept, shift by whole windows until the top window is nonzero, then hold
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r  <= IDLE;
            data_r   <= '0;
            shamt_r  <= '0;
            zero_r   <= 1'b0;
            sticky_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: if (v_i) begin
                    data_r   <= data_i;
                    sticky_r <= sticky_i;
`ifdef BSG_FPU_NORMALIZE_ZERO_FAST_EN
                    zero_r   <= ~|data_i;
                    shamt_r  <= ~|data_i ? lg_width_p'(width_p) : '0;
                    state_r  <= ~|data_i ? DONE : SHIFT;
`else
                    zero_r   <= 1'b0;
                    shamt_r  <= '0;
                    state_r  <= SHIFT;
`endif
                end
                SHIFT: if (~|data_r) begin
                    shamt_r <= lg_width_p'(width_p);
                    zero_r  <= 1'b1;
                    state_r <= DONE;
                end else if (win_zero) begin
                    data_r  <= data_r << step_p;
                    shamt_r <= shamt_r + lg_width_p'(step_p);
                end else begin
                    data_r  <= data_r << lzc;
                    shamt_r <= shamt_r + lg_width_p'(lzc);
                    state_r <= DONE;
                end
                DONE: if (yumi_i) state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    assign ready_o  = (state_r == IDLE);
    assign v_o      = (state_r == DONE);
    assign data_o   = data_r;
    assign shamt_o  = shamt_r;
    assign zero_o   = zero_r;
    assign sticky_o = sticky_r;

    yumi_only_when_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);

endmodule

// File: tb/tb_bsg_fpu_normalize_iter.sv
// tb_bsg_fpu_normalize_iter: directed vectors, scoreboard queue checked by an output monitor
module tb_bsg_fpu_normalize_iter;

    logic        clk = 1'b0;
    logic        reset_n_i = 1'b1;
    logic        v_i = 1'b0;
    logic [31:0] data_i = '0;
    logic        sticky_i = 1'b0;
    logic        ready_o, v_o, zero_o, sticky_o;
    logic [31:0] data_o;
    logic [5:0]  shamt_o;
    logic        yumi_i = 1'b0;

    int checks = 0;
    int failures = 0;

`ifdef BSG_FPU_NORMALIZE_ZERO_FAST_EN
    localparam int zlat = 1;
`else
    localparam int zlat = 2;
`endif

    typedef struct packed {
        logic [31:0] d;
        logic [5:0]  sh;
        logic        z;
        logic        s;
    } exp_t;

    typedef struct {
        logic [31:0] d;
        logic        s;
        logic [31:0] ed;
        int          sh;
        logic        z;
        int          lat;
    } vec_t;

    exp_t q[$];
    logic seen = 1'b0;

    vec_t vecs[9] = '{
        '{32'h0000_0001, 1'b1, 32'h8000_0000, 31, 1'b0, 5},
        '{32'h8000_0000, 1'b0, 32'h8000_0000,  0, 1'b0, 2},
        '{32'h00F0_0000, 1'b0, 32'hF000_0000,  8, 1'b0, 3},
        '{32'h0000_0000, 1'b1, 32'h0000_0000, 32, 1'b1, zlat},
        '{32'h0001_2345, 1'b0, 32'h91A2_8000, 15, 1'b0, 3},
        '{32'h0000_00FF, 1'b1, 32'hFF00_0000, 24, 1'b0, 5},
        '{32'h4000_0000, 1'b0, 32'h8000_0000,  1, 1'b0, 2},
        '{32'h0080_0000, 1'b1, 32'h8000_0000,  8, 1'b0, 3},
        '{32'h0100_0000, 1'b0, 32'h8000_0000,  7, 1'b0, 2}
    };

    bsg_fpu_normalize_iter #(.width_p(32), .step_p(8)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n_i),
        .v_i       (v_i),
        .data_i    (data_i),
        .sticky_i  (sticky_i),
        .ready_o   (ready_o),
        .v_o       (v_o),
        .data_o    (data_o),
        .shamt_o   (shamt_o),
        .zero_o    (zero_o),
        .sticky_o  (sticky_o),
        .yumi_i    (yumi_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: pop and compare once per presented result
    always @(negedge clk) begin
        if (v_o && !seen) begin
            if (q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("data_o", data_o, e.d);
                check("shamt_o", 32'(shamt_o), 32'(e.sh));
                check("zero_o", 32'(zero_o), 32'(e.z));
                check("sticky_o", 32'(sticky_o), 32'(e.s));
            end
        end
        seen = v_o;
    end

    task automatic run(input logic [31:0] d, input logic s, input logic [31:0] ed,
                       input int sh, input logic z, input int lat, input int hold);
        int n;
        check("ready_before_accept", 32'(ready_o), 32'd1);
        v_i = 1'b1;
        data_i = d;
        sticky_i = s;
        q.push_back('{d: ed, sh: 6'(sh), z: z, s: s});
        @(posedge clk); #1;
        v_i = 1'b0;
        data_i = 32'h5A5A_5A5A;
        sticky_i = ~s;
        n = 1;
        while (!v_o && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency_edges", 32'(n), 32'(lat));
        for (int i = 0; i < hold; i++) begin
            v_i = 1'b1;
            data_i = 32'hDEAD_BEEF;
            sticky_i = 1'b0;
            @(posedge clk); #1;
            check("hold_ready", 32'(ready_o), 32'd0);
            check("hold_v", 32'(v_o), 32'd1);
            check("hold_data", data_o, ed);
            check("hold_shamt", 32'(shamt_o), 32'(sh));
            check("hold_sticky", 32'(sticky_o), 32'(s));
        end
        yumi_i = 1'b1;
        @(posedge clk); #1;
        yumi_i = 1'b0;
        check("post_yumi_ready", 32'(ready_o), 32'd1);
        check("post_yumi_v", 32'(v_o), 32'd0);
    endtask

    initial begin
        #2 reset_n_i = 1'b0;
        #1;
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_v", 32'(v_o), 32'd0);
        check("rst_data", data_o, 32'd0);
        check("rst_shamt", 32'(shamt_o), 32'd0);
        check("rst_zero", 32'(zero_o), 32'd0);
        check("rst_sticky", 32'(sticky_o), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset_n_i = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i])
            run(vecs[i].d, vecs[i].s, vecs[i].ed, vecs[i].sh, vecs[i].z, vecs[i].lat, 0);

        run(32'h0000_0300, 1'b1, 32'hC000_0000, 22, 1'b0, 4, 5);
        run(32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 0, 1'b0, 2, 0);

        v_i = 1'b1;
        data_i = 32'h0000_0001;
        sticky_i = 1'b1;
        @(posedge clk); #1;
        v_i = 1'b0;
        @(posedge clk); #1;
        reset_n_i = 1'b0;
        #1;
        check("midrst_v", 32'(v_o), 32'd0);
        check("midrst_ready", 32'(ready_o), 32'd1);
        check("midrst_data", data_o, 32'd0);
        @(posedge clk); #1;
        reset_n_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("midrst_no_result", 32'(v_o), 32'd0);
        end
        run(32'h0000_0001, 1'b1, 32'h8000_0000, 31, 1'b0, 5, 0);
        run(32'h0000_0000, 1'b0, 32'h0000_0000, 32, 1'b1, zlat, 0);

        @(posedge clk); @(posedge clk); #1;
        check("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
